uart_interface: RTL and testbench

Byte-wide 8N1 UART peripheral on the maxicore32 I/O bus. It drives the board's `uarttx` pin and samples `uartrx`, both currently unused at board level. Its read path feeds `data_in_mux` in the same way as the PS/2, tone generator and I2C peripherals. It provides a one-byte TX holding register and a 4-entry RX FIFO, polled through a status register.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_interface.sv | 209 ++++++++++++++++++++
 tb/tb_uart_interface.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared FSM encodings, status bit positions and FIFO depth.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_BUSY      = 1;
  localparam int ST_RX_OVERRUN   = 2;

  localparam int RX_FIFO_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 4-entry byte FIFO; a pop frees the slot for a same-edge push.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  localparam logic [2:0] DEPTH = 3'(RX_FIFO_DEPTH);

  logic [7:0] r_mem [RX_FIFO_DEPTH];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic       w_do_pop;
  logic       w_do_push;

  assign empty     = (r_count == 3'd0);
  assign full      = (r_count == DEPTH);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 3'd1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_interface.sv
`default_nettype none
// ============================================================================
// Module   : uart_interface
// Purpose  : 8N1 UART with one-byte TX holding register and 4-entry RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_interface
  import uart_pkg::*;
#(
  parameter int          CLOCK_HZ = 12500000,
  parameter int          BAUD     = 115200,
  parameter logic [15:0] DIVISOR  = 16'((CLOCK_HZ + BAUD / 2) / BAUD)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        status_cs,
  input  logic        data_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        uartrx,
  output logic        uarttx
);

  localparam logic [15:0] HALF_DIVISOR = DIVISOR >> 1;

  // ---------------- transmitter ----------------
  tx_state_t   r_tx_state, w_tx_state_next;
  logic [15:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]  r_tx_bit, w_tx_bit_next;
  logic [7:0]  r_tx_shift, w_tx_shift_next;
  logic        r_uarttx, w_uarttx_next;
  logic        w_tx_busy, w_tx_load, w_tx_tick;

  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign w_tx_load = write && data_cs && !w_tx_busy;
  assign w_tx_tick = (r_tx_cnt == DIVISOR - 16'd1);
  assign uarttx    = r_uarttx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_uarttx   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_uarttx   <= w_uarttx_next;
    end
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + 16'd1;
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = 16'd0;
        if (w_tx_load) begin
          w_tx_state_next = TX_START;
          w_tx_shift_next = data_in[7:0];
        end
      end
      TX_START: if (w_tx_tick) begin
        w_tx_state_next = TX_DATA;
        w_tx_cnt_next   = 16'd0;
        w_tx_bit_next   = 3'd0;
      end
      TX_DATA: if (w_tx_tick) begin
        w_tx_cnt_next   = 16'd0;
        w_tx_bit_next   = r_tx_bit + 3'd1;
        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
        if (r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
      end
      TX_STOP: if (w_tx_tick) begin
        w_tx_state_next = TX_IDLE;
        w_tx_cnt_next   = 16'd0;
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin itself comes from a flop.
  always_comb begin
    w_uarttx_next = 1'b1;
    case (w_tx_state_next)
      TX_START: w_uarttx_next = 1'b0;
      TX_DATA:  w_uarttx_next = w_tx_shift_next[0];
      default:  w_uarttx_next = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]  r_rx_sync;
  rx_state_t   r_rx_state, w_rx_state_next;
  logic [15:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]  r_rx_bit, w_rx_bit_next;
  logic [7:0]  r_rx_shift, w_rx_shift_next;
  logic        w_rx_line, w_rx_tick, w_rx_push;

  assign w_rx_line = r_rx_sync[1];
  assign w_rx_tick = (r_rx_cnt == DIVISOR - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uartrx};
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt + 16'd1;
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = 16'd0;
        if (!w_rx_line) w_rx_state_next = RX_START;
      end
      RX_START: if (r_rx_cnt == HALF_DIVISOR - 16'd1) begin
        w_rx_cnt_next   = 16'd0;
        w_rx_bit_next   = 3'd0;
        w_rx_state_next = w_rx_line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_rx_tick) begin
        w_rx_cnt_next   = 16'd0;
        w_rx_bit_next   = r_rx_bit + 3'd1;
        w_rx_shift_next = {w_rx_line, r_rx_shift[7:1]};
        if (r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
      end
      RX_STOP: if (w_rx_tick) begin
        w_rx_cnt_next   = 16'd0;
        w_rx_state_next = RX_IDLE;
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  // A stop sample of 0 is a framing error: the byte is silently discarded.
  always_comb begin
    w_rx_push = (r_rx_state == RX_STOP) && w_rx_tick && w_rx_line;
  end

  // ---------------- FIFO, status and bus ----------------
  logic [7:0] w_fifo_head;
  logic       w_fifo_full, w_fifo_empty;
  logic [2:0] w_fifo_count;
  logic       w_rx_pop_req, w_status_rd, r_rx_overrun;
  logic       w_unused_data;

  assign w_rx_pop_req  = read && data_cs && !status_cs;
  assign w_status_rd   = read && status_cs;
  assign w_unused_data = ^data_in[31:8];

  uart_rx_fifo u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_rx_push),
    .pop       (w_rx_pop_req),
    .push_data (r_rx_shift),
    .head_data (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // A same-edge pop makes room, so a push while full only overruns without one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_overrun <= 1'b0;
    end else if (w_rx_push && w_fifo_full && !w_rx_pop_req) begin
      r_rx_overrun <= 1'b1;
    end else if (w_status_rd) begin
      r_rx_overrun <= 1'b0;
    end
  end

  assign data_out_valid = read && (status_cs || data_cs);

  always_comb begin
    data_out = 32'd0;
    if (w_status_rd) begin
      data_out[ST_RX_NOT_EMPTY] = (w_fifo_count != 3'd0);
      data_out[ST_TX_BUSY]      = w_tx_busy;
      data_out[ST_RX_OVERRUN]   = r_rx_overrun;
    end else if (w_rx_pop_req && !w_fifo_empty) begin
      data_out[7:0] = w_fifo_head;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_interface
// Purpose  : Randomised bench for uart_interface against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_interface;

  localparam int D      = 109;
  localparam int FRAME  = 10 * D;
  localparam int RX_LAT = 2 + D / 2 + 9 * D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0, status_cs = 1'b0, data_cs = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        uartrx = 1'b1;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        uarttx;

  uart_interface dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .write          (write),
    .status_cs      (status_cs),
    .data_cs        (data_cs),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .uartrx         (uartrx),
    .uarttx         (uarttx)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad = 0;
  int   e = 0;
  bit   chk_en = 1'b0;
  int   tx_start = -1;
  logic [7:0] tx_byte = 8'd0;
  logic [7:0] q[$];
  logic m_ovr = 1'b0;
  int   pend_edge[$];
  logic [7:0] pend_byte[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  function automatic bit m_busy(input int k);
    return (tx_start >= 0) && ((k - tx_start) < FRAME);
  endfunction

  // Frame slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  function automatic logic m_line(input int k);
    int n;
    if (!m_busy(k)) return 1'b1;
    n = (k - tx_start) / D;
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return tx_byte[n-1];
  endfunction

  function automatic logic [31:0] m_status();
    return {29'd0, m_ovr, m_busy(e), q.size() != 0};
  endfunction

  // Reference model: advances once per clock edge from the bench's own stimulus.
  always @(posedge clock) begin
    bit pop, push;
    logic [7:0] pb;
    e = e + 1;
    push = 1'b0;
    pb   = 8'd0;
    if (pend_edge.size() != 0 && pend_edge[0] == e) begin
      push = 1'b1;
      pb   = pend_byte[0];
      void'(pend_edge.pop_front());
      void'(pend_byte.pop_front());
    end
    if (reset) begin
      chk_en   = 1'b1;
      tx_start = -1;
      q.delete();
      m_ovr = 1'b0;
      pend_edge.delete();
      pend_byte.delete();
    end else begin
      if (write && data_cs && !m_busy(e - 1)) begin
        tx_start = e;
        tx_byte  = data_in[7:0];
      end
      pop = read && data_cs && !status_cs && (q.size() != 0);
      if (read && status_cs) m_ovr = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < 4) q.push_back(pb);
        else m_ovr = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("uarttx", 32'(uarttx), 32'(m_line(e)));
      check("valid", 32'(data_out_valid), 32'(read && (status_cs || data_cs)));
      if (read && status_cs) check("status", data_out, m_status());
      else if (read && data_cs) check("rdata", data_out, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
    end
  end

  task automatic bus(input bit rd, input bit wr, input bit scs, input bit dcs, input logic [7:0] d);
    @(posedge clock);
    #1;
    read = rd; write = wr; status_cs = scs; data_cs = dcs;
    data_in = {24'($urandom), d};
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    @(negedge clock);
    v = data_out;
  endtask

  task automatic rd_data(output logic [31:0] v);
    bus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    @(negedge clock);
    v = data_out;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    @(posedge clock);
    #1;
    uartrx = 1'b0;
    if (stop_ok) begin
      pend_edge.push_back(e + 1 + RX_LAT);
      pend_byte.push_back(b);
    end
    for (int i = 1; i < 10; i++) begin
      repeat (D) @(posedge clock);
      #1;
      uartrx = f[i];
    end
    repeat (D) @(posedge clock);
    #1;
    uartrx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  a5_frame;
    int          busy_n;
    int          tgt;
    a5_frame = 10'b1_1010_0101_0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_uarttx", 32'(uarttx), 32'd1);
    check("rst_data_out", data_out, 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      idle(99);
      rd_status(v);
      check("idle_status", v, 32'd0);
    end
    idle(1);

    // 0xA5 frame: poll status every cycle to time tx_busy and sample mid-bit.
    bus(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    busy_n = 0;
    for (int i = 0; i < 1200; i++) begin
      rd_status(v);
      if (v[1]) busy_n++;
      if (i < FRAME && (i % D) == D / 2) check("tx_a5_bit", 32'(uarttx), 32'(a5_frame[i / D]));
      if (!v[1]) break;
    end
    check("tx_busy_len", busy_n, FRAME);
    idle(1);

    bus(1'b0, 1'b1, 1'b0, 1'b1, 8'h96);
    idle(300);
    bus(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    idle(FRAME);

    send_rx(8'h3C, 1'b1);
    idle(5);
    rd_status(v); check("rx_status", v, 32'h1);
    rd_data(v);   check("rx_data", v, 32'h3C);
    rd_status(v); check("rx_status_after", v, 32'h0);
    idle(1);

    for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
    idle(5);
    rd_status(v); check("ovr_status", v, 32'h5);
    for (int b = 1; b <= 4; b++) begin
      rd_data(v); check("ovr_data", v, 32'(b));
    end
    rd_status(v); check("ovr_cleared", v, 32'h0);
    idle(1);

    @(posedge clock); #1; uartrx = 1'b0;
    repeat (20) @(posedge clock);
    #1; uartrx = 1'b1;
    idle(1200);
    rd_status(v); check("glitch_status", v, 32'h0);
    idle(1);
    send_rx(8'h77, 1'b0);
    idle(200);
    rd_status(v); check("framing_status", v, 32'h0);
    idle(1);

    // Full FIFO: the fifth byte completes on the same edge as a data read.
    for (int b = 8'h11; b <= 8'h14; b++) send_rx(8'(b), 1'b1);
    fork
      send_rx(8'h15, 1'b1);
      begin
        @(posedge clock);
        #1;
        tgt = e + 1 + RX_LAT;
        while (e < tgt - 1) begin
          @(posedge clock);
          #1;
        end
        read = 1'b1; data_cs = 1'b1;
        @(negedge clock);
        check("simul_data", data_out, 32'h11);
        @(posedge clock);
        #1;
        read = 1'b0; data_cs = 1'b0;
      end
    join
    idle(5);
    rd_status(v); check("simul_status", v, 32'h1);
    for (int b = 8'h12; b <= 8'h15; b++) begin
      rd_data(v); check("simul_drain", v, 32'(b));
    end
    rd_status(v); check("simul_empty", v, 32'h0);
    idle(1);

    bus(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);
    idle(4 * D + 30);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    check("rst_mid_uarttx", 32'(uarttx), 32'd1);
    rd_status(v); check("rst_mid_status", v, 32'h0);
    idle(1);

    fork
      begin
        for (int i = 0; i < 9000; i++) begin
          int r;
          r = int'($urandom % 100);
          if (r < 3)       bus(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
          else if (r < 6)  bus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
          else if (r < 10) bus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
          else             bus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        idle(1);
      end
      begin
        for (int j = 0; j < 6; j++) begin
          bit ok;
          ok = ($urandom % 8) != 0;
          send_rx(8'($urandom), ok);
          repeat (ok ? $urandom_range(0, 40) : 200 + $urandom_range(0, 40)) @(posedge clock);
        end
      end
    join
    idle(1200);
    for (int i = 0; i < 6; i++) begin
      rd_data(v);
    end
    rd_status(v);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
